// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter:
// FSM state encoding and frame constants.
package uart_tx_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;
    localparam int BIT_IDX_W  = $clog2(DATA_BITS);

    // Line level driven while the FSM sits in a given state.
    function automatic logic line_level(input tx_state_e st, input logic data_lsb);
        logic lvl;
        lvl = 1'b1;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = data_lsb;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with occupancy count; pushes into a full FIFO and pops
// from an empty FIFO are ignored, so the count can neither wrap nor underflow.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        do_push  = rst && push && !full;
        do_pop   = rst && pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers characters from the core's simulated UART port and serialises them
// as 8N1 on tx; the core is never stalled, overflowing characters are dropped.
import uart_tx_buffer_pkg::*;

module uart_tx_buffer #(
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 868
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               char_in,
    input  logic                     char_valid,
    output logic                     tx,
    output logic                     busy,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [7:0]            fifo_dout;
    logic                  baud_end;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (char_valid),
        .pop   (fifo_pop),
        .din   (char_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        baud_end   = (cnt_q == BAUD_LAST);
        overflow_d = overflow_q || (char_valid && fifo_full);
        // tx follows the state held during the cycle, one edge late, so the
        // line only ever changes on a clock edge.
        tx_d       = line_level(state_q, shift_q[0]);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule
